// File: rtl/axi_async_w_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_async_w_arb_pkg
// Brief    : Shared state encoding and sizing helper for the write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axi_async_w_arb_pkg;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_busy = 1'b1;

    // Ceiling log2; returns 0 for an input of 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_async_w_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Round-robin selector, first set request at or above ptr (wrapping).
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import axi_async_w_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] w_doubled;
    logic [2*N-1:0] w_shifted;
    logic [N-1:0]   w_rot;
    logic [PW-1:0]  w_off;
    logic [PW:0]    w_sum;

    // Rotate so that bit 0 of w_rot is requester ptr; the lowest set bit wins.
    always_comb begin
        w_doubled = {req, req};
        w_shifted = w_doubled >> ptr;
        w_rot     = w_shifted[N-1:0];
        w_off     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PW'(k);
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (PW+1)'(N)) begin
            w_sum = w_sum - (PW+1)'(N);
        end
        idx = w_sum[PW-1:0];
        any = |req;
    end

endmodule
`default_nettype wire

// File: rtl/axi_async_w_arb.sv
`default_nettype none
// ============================================================================
// Module   : axi_async_w_arb
// Brief    : Round-robin N:1 write arbiter feeding an async write channel.
// Revision : 1.0 - initial release
// ============================================================================
module axi_async_w_arb
    import axi_async_w_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int aw   = 4,
    parameter int w    = 32,
    parameter int MAXB = 8
) (
    input  logic           clka,
    input  logic           rst_n,
    input  logic [N-1:0]   s_valid,
    output logic [N-1:0]   s_ready,
    input  logic [N-1:0]   s_last,
    input  logic [N*aw-1:0] s_addr,
    input  logic [N*w-1:0] s_data,
    output logic           wvalida,
    input  logic           wreadya,
    output logic [aw-1:0]  waddra,
    output logic [w-1:0]   wdataa,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int GW = clog2(N);
    localparam int CW = (clog2(MAXB) < 1) ? 1 : clog2(MAXB);
    localparam logic [GW-1:0] c_last_idx = GW'(N - 1);
    localparam logic [CW-1:0] c_cnt_max  = CW'(MAXB - 1);

    logic [0:0]    r_state;
    logic [0:0]    w_next_state;
    logic [GW-1:0] r_g;
    logic [GW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic          w_owner_valid;
    logic          w_owner_last;
    logic          w_beat;
    logic          w_release;

    rr_pick #(
        .N  (N),
        .PW (GW)
    ) u_rr_pick (
        .req (s_valid),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_g == GW'(i)) begin
                w_owner_valid = s_valid[i];
                w_owner_last  = s_last[i];
            end
        end
    end

    // Hitting MAXB releases silently; the requester's next beat re-arbitrates.
    assign w_beat    = (r_state == c_busy) && w_owner_valid && wreadya;
    assign w_release = w_beat && (w_owner_last || (r_cnt == c_cnt_max));

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_pick_any) w_next_state = c_busy;
            c_busy:  if (w_release)  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_g   <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (r_state == c_idle) begin
            if (w_pick_any) begin
                r_g   <= w_pick_idx;
                r_cnt <= '0;
            end
        end else if (w_beat) begin
            if (w_release) begin
                r_ptr <= (r_g == c_last_idx) ? '0 : r_g + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        wvalida = 1'b0;
        waddra  = '0;
        wdataa  = '0;
        s_ready = '0;
        grant   = '0;
        busy    = (r_state == c_busy);
        if (r_state == c_busy) begin
            for (int i = 0; i < N; i++) begin
                if (r_g == GW'(i)) begin
                    wvalida    = s_valid[i];
                    waddra     = s_addr[i*aw +: aw];
                    wdataa     = s_data[i*w +: w];
                    s_ready[i] = wreadya;
                    grant[i]   = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_async_w_arb.md
AXI_ASYNC_W_ARB -- requirements
Module: axi_async_w_arb

Interface
REQ-001 Parameter N, default 4: number of clka-domain write requesters, range 2..16.
REQ-002 Parameter aw, default 4: address width.
REQ-003 Parameter w, default 32: data width.
REQ-004 Parameter MAXB, default 8: maximum beats per grant, range 1..256.
REQ-005 Port list (name, direction, width, meaning):
- clka  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_valid  in  N  requester i write valid (bit i).
- s_ready  out  N  requester i write ready.
- s_last  in  N  requester i current beat ends its burst.
- s_addr  in  N*aw  requester i address in bits [i*aw +: aw].
- s_data  in  N*w  requester i data in bits [i*w +: w].
- wvalida  out  1  valid to the async write channel.
- wreadya  in  1  ready from the async write channel.
- waddra  out  aw  address to the channel.
- wdataa  out  w  data to the channel.
- grant  out  N  one-hot current owner; all zero when idle.
- busy  out  1  high while in state BUSY.

Function
REQ-006 FSM states: IDLE and BUSY; registers: state, owner index g, round-robin pointer ptr (0..N-1), beat counter cnt (0..MAXB-1).
REQ-007 Arbitration: in IDLE with any s_valid set, select the first set bit searching upward from ptr with wrap N-1->0; latch it as g; clear cnt; go to BUSY on the next edge.
REQ-008 In IDLE: no s_valid -> remain in IDLE.
REQ-009 In IDLE: wvalida=0, s_ready=0, grant=0; waddra/wdataa are don't-care.
REQ-010 In BUSY, combinational pass-through: wvalida=s_valid[g], waddra=s_addr[g], wdataa=s_data[g], s_ready[g]=wreadya, all other s_ready bits 0, grant=1<<g.
REQ-011 Beat = BUSY and wvalida and wreadya.
REQ-012 On a beat with s_last[g]=0 and cnt<MAXB-1: increment cnt; stay in BUSY.
REQ-013 On a beat with s_last[g]=1 or cnt=MAXB-1: go to IDLE; ptr=(g+1) mod N.
REQ-014 Forced release at MAXB is not signalled to the requester; its later beats re-arbitrate as a new burst.
REQ-015 In BUSY with s_valid[g]=0: hold state, g and cnt; no timeout.
REQ-016 Arbitration latency: one IDLE cycle between successive grants, including back-to-back grants to the same requester.
REQ-017 Simultaneous requests: exactly one grant; the others wait with s_ready=0.
REQ-018 Changes of s_valid on non-owners never affect the outputs while BUSY.
REQ-019 Sustained throughput with wreadya held high: MAXB beats per MAXB+1 cycles.

Reset
REQ-020 While rst_n=0: state=IDLE, g=0, ptr=0, cnt=0; wvalida=0, s_ready=0, grant=0, busy=0.
REQ-021 Reset asserted mid-burst aborts the burst; the first grant after release goes to the lowest-index valid requester.
REQ-022 rst_n is shared with the async channel, so both sides reset together.

Structure
REQ-023 The state encoding constants (IDLE=0, BUSY=1) belong in the shared common package.
REQ-024 The package also holds a clog2 function, used to size g, ptr (clog2(N)) and cnt (clog2(MAXB), minimum 1).
REQ-025 The round-robin selector is a sub-module rr_pick: inputs req[N] and ptr; outputs idx and any; purely combinational.
REQ-026 The FSM and datapath mux live in axi_async_w_arb.

Verification
REQ-027 Single requester 2 writes addr 3, data 0xA5A5A5A5 with s_last=1 each, wreadya=1 -> two beats on the channel with one idle cycle between them; grant=0001 during each beat.
REQ-028 All 4 requesters valid from reset, single-beat bursts -> grant order 0,1,2,3,0; ptr wraps 3->0.
REQ-029 Requester 2 sends a 12-beat burst (s_last on beat 12), MAXB=8, requester 0 also valid -> 8 beats from 2, then grant to 0, then the remaining 4 beats from 2.
REQ-030 wreadya held low for 5 cycles during a beat -> wvalida, waddra and wdataa stay stable; cnt unchanged; no grant change.
REQ-031 rst_n pulsed low on beat 3 of a burst from requester 1 -> all outputs 0 within the reset; after release, requester 0 (valid) is granted first.
REQ-032 Owner drops s_valid for 10 cycles mid-burst while others are valid -> grant held; the burst resumes with cnt continuing.
